alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/core_types_pkg.sv | 31 +++
 rtl/alu.sv | 36 +++
 rtl/alu_arbiter.sv | 92 +++++++++
 tb/tb_alu_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: ALU opcodes, arbiter state encoding and the ALU result bundle.
package core_types_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    typedef enum logic {
        ARB_EMPTY,
        ARB_FULL
    } arb_state_t;

    typedef struct packed {
        logic [31:0] out;
        logic        zero;
        logic        lt;
        logic        ltu;
    } alu_res_t;

endpackage

// File: rtl/alu.sv
// Core 32-bit combinational ALU; zero latency, no flow control.
// lt/ltu always compare the raw operands, independent of the selected operation.
module alu
    import core_types_pkg::*;
(
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  alu_op_t     alu_op,
    output logic [31:0] out,
    output logic        zero,
    output logic        lt,
    output logic        ltu
);

    always_comb begin
        lt  = $signed(op1) < $signed(op2);
        ltu = op1 < op2;
        out = '0;
        case (alu_op)
            ALU_ADD:  out = op1 + op2;
            ALU_SUB:  out = op1 - op2;
            ALU_SLL:  out = op1 << op2[4:0];
            ALU_SLT:  out = {31'b0, lt};
            ALU_SLTU: out = {31'b0, ltu};
            ALU_XOR:  out = op1 ^ op2;
            ALU_SRL:  out = op1 >> op2[4:0];
            ALU_SRA:  out = $unsigned($signed(op1) >>> op2[4:0]);
            ALU_OR:   out = op1 | op2;
            ALU_AND:  out = op1 & op2;
            default:  out = '0;
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one ALU between two requesters; latency 1 into a single result register.
// A held result blocks new grants until its owner drains it; drain and accept may overlap with no bubble.
module alu_arbiter
    import core_types_pkg::*;
#(
    parameter int NUM_REQ = core_types_pkg::NUM_REQ
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0][31:0]  req_op1,
    input  logic [NUM_REQ-1:0][31:0]  req_op2,
    input  alu_op_t [NUM_REQ-1:0]     req_alu_op,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [31:0]               rsp_out,
    output logic                      rsp_zero,
    output logic                      rsp_lt,
    output logic                      rsp_ltu,
    input  logic                      flush
);

    arb_state_t state_q, state_d;
    logic       owner_q;
    logic       last_grant_q;
    alu_res_t   res_q;
    alu_res_t   alu_res;
    logic       gnt_id;
    logic       drain;
    logic       can_accept;
    logic       accept;

    // With both requesting, the one not granted last wins.
    always_comb begin
        case (req_valid)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            default: gnt_id = ~last_grant_q;
        endcase
    end

    assign drain      = (state_q == ARB_FULL) && rsp_ready[owner_q];
    assign can_accept = (state_q == ARB_EMPTY) || drain;
    assign accept     = (|req_valid) && can_accept && !flush && !rst;

    assign req_ready  = accept ? {gnt_id, ~gnt_id} : 2'b00;
    assign rsp_valid  = (state_q == ARB_FULL) ? {owner_q, ~owner_q} : 2'b00;

    alu u_alu (
        .op1    (req_op1[gnt_id]),
        .op2    (req_op2[gnt_id]),
        .alu_op (req_alu_op[gnt_id]),
        .out    (alu_res.out),
        .zero   (alu_res.zero),
        .lt     (alu_res.lt),
        .ltu    (alu_res.ltu)
    );

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ARB_EMPTY;
        end else if (accept) begin
            state_d = ARB_FULL;
        end else if (drain) begin
            state_d = ARB_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_EMPTY;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            res_q        <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                res_q        <= alu_res;
                owner_q      <= gnt_id;
                last_grant_q <= gnt_id;
            end
        end
    end

    assign rsp_out  = res_q.out;
    assign rsp_zero = res_q.zero;
    assign rsp_lt   = res_q.lt;
    assign rsp_ltu  = res_q.ltu;

endmodule

// File: tb/tb_alu_arbiter.sv
// Cycle table for the shared-ALU arbiter, followed by a streaming and a latency sequence.
module tb_alu_arbiter;
    import core_types_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][31:0]  req_op1;
    logic [1:0][31:0]  req_op2;
    alu_op_t [1:0]     req_alu_op;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [31:0]       rsp_out;
    logic              rsp_zero;
    logic              rsp_lt;
    logic              rsp_ltu;
    logic              flush;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_alu_op (req_alu_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_out    (rsp_out),
        .rsp_zero   (rsp_zero),
        .rsp_lt     (rsp_lt),
        .rsp_ltu    (rsp_ltu),
        .flush      (flush)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic [1:0]  vld;
        logic [1:0]  rrdy;
        alu_op_t     op0;
        logic [31:0] a0;
        logic [31:0] b0;
        alu_op_t     op1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [1:0]  e_rdy;
        logic [1:0]  e_vld;
        logic [31:0] e_out;
        logic        e_z;
        logic        e_lt;
        logic        e_ltu;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst           = v.rst;
        flush         = v.flush;
        req_valid     = v.vld;
        rsp_ready     = v.rrdy;
        req_alu_op[0] = v.op0;
        req_op1[0]    = v.a0;
        req_op2[0]    = v.b0;
        req_alu_op[1] = v.op1;
        req_op1[1]    = v.a1;
        req_op2[1]    = v.b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        last_g;
        logic        g;
        logic [1:0]  prev_g;
        logic [31:0] prev_out;
        int          lat;

        // rst flush vld rrdy | op0 a0 b0 | op1 a1 b1 | rdy vld out z lt ltu
        tbl.push_back(vec_t'{1, 0, 2'b01, 2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b01, 2'b00, ALU_ADD, 5, 7, ALU_ADD, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b00, 2'b00, ALU_ADD, 5, 7, ALU_ADD, 0, 0, 2'b00, 2'b01, 12, 0, 1, 1});
        tbl.push_back(vec_t'{0, 0, 2'b01, 2'b00, ALU_SUB, 3, 3, ALU_ADD, 0, 0, 2'b00, 2'b01, 12, 0, 1, 1});
        tbl.push_back(vec_t'{0, 0, 2'b01, 2'b01, ALU_SUB, 3, 3, ALU_ADD, 0, 0, 2'b01, 2'b01, 12, 0, 1, 1});
        tbl.push_back(vec_t'{0, 0, 2'b01, 2'b00, ALU_ADD, 9, 1, ALU_ADD, 20, 4, 2'b00, 2'b01, 0, 1, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b01, 2'b00, ALU_ADD, 9, 1, ALU_ADD, 20, 4, 2'b00, 2'b01, 0, 1, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b01, 2'b00, ALU_ADD, 9, 1, ALU_ADD, 20, 4, 2'b00, 2'b01, 0, 1, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b01, 2'b01, ALU_ADD, 9, 1, ALU_ADD, 20, 4, 2'b01, 2'b01, 0, 1, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b11, 2'b11, ALU_ADD, 9, 1, ALU_ADD, 20, 4, 2'b10, 2'b01, 10, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b11, 2'b11, ALU_ADD, 9, 1, ALU_ADD, 20, 4, 2'b01, 2'b10, 24, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b11, 2'b11, ALU_ADD, 9, 1, ALU_ADD, 20, 4, 2'b10, 2'b01, 10, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b00, 2'b11, ALU_ADD, 9, 1, ALU_ADD, 20, 4, 2'b00, 2'b10, 24, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b00, 2'b11, ALU_ADD, 9, 1, ALU_ADD, 20, 4, 2'b00, 2'b00, 0, 0, 0, 0});
        // fresh reset: alternation must begin with requester 0
        tbl.push_back(vec_t'{1, 0, 2'b11, 2'b11, ALU_ADD, 9, 1, ALU_ADD, 20, 4, 2'b00, 2'b00, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b11, 2'b11, ALU_ADD, 9, 1, ALU_ADD, 20, 4, 2'b01, 2'b00, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b11, 2'b11, ALU_ADD, 9, 1, ALU_ADD, 20, 4, 2'b10, 2'b01, 10, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b11, 2'b11, ALU_ADD, 9, 1, ALU_ADD, 20, 4, 2'b01, 2'b10, 24, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b00, 2'b11, ALU_ADD, 9, 1, ALU_ADD, 20, 4, 2'b00, 2'b01, 10, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b00, 2'b11, ALU_ADD, 9, 1, ALU_ADD, 20, 4, 2'b00, 2'b00, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b10, 2'b00, ALU_ADD, 0, 0, ALU_SRA, 32'h8000_0000, 32'h21, 2'b10, 2'b00, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b10, 2'b10, ALU_ADD, 0, 0, ALU_SLT, 32'hFFFF_FFFF, 1, 2'b10, 2'b10, 32'hC000_0000, 0, 1, 0});
        tbl.push_back(vec_t'{0, 0, 2'b00, 2'b00, ALU_ADD, 0, 0, ALU_SLT, 32'hFFFF_FFFF, 1, 2'b00, 2'b10, 1, 0, 1, 0});
        tbl.push_back(vec_t'{0, 0, 2'b01, 2'b01, ALU_XOR, 2, 3, ALU_SLT, 32'hFFFF_FFFF, 1, 2'b00, 2'b10, 1, 0, 1, 0});
        tbl.push_back(vec_t'{0, 0, 2'b00, 2'b10, ALU_XOR, 2, 3, ALU_ADD, 0, 0, 2'b00, 2'b10, 1, 0, 1, 0});
        // flush while FULL owned by requester 0
        tbl.push_back(vec_t'{0, 0, 2'b01, 2'b00, ALU_XOR, 2, 3, ALU_ADD, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 1, 2'b01, 2'b00, ALU_XOR, 2, 3, ALU_ADD, 0, 0, 2'b00, 2'b01, 1, 0, 1, 1});
        tbl.push_back(vec_t'{0, 0, 2'b01, 2'b00, ALU_XOR, 2, 3, ALU_ADD, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b00, 2'b00, ALU_XOR, 2, 3, ALU_ADD, 0, 0, 2'b00, 2'b01, 1, 0, 1, 1});
        // reset with a drain and a pending request in the same cycle
        tbl.push_back(vec_t'{1, 0, 2'b01, 2'b01, ALU_XOR, 2, 3, ALU_ADD, 0, 0, 2'b00, 2'b01, 1, 0, 1, 1});
        tbl.push_back(vec_t'{0, 0, 2'b11, 2'b00, ALU_AND, 7, 7, ALU_ADD, 20, 4, 2'b01, 2'b00, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b00, 2'b00, ALU_AND, 7, 7, ALU_ADD, 20, 4, 2'b00, 2'b01, 7, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b01, 2'b01, ALU_SLL, 1, 32'h24, ALU_ADD, 0, 0, 2'b01, 2'b01, 7, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 2'b00, 2'b01, ALU_SLL, 1, 32'h24, ALU_ADD, 0, 0, 2'b00, 2'b01, 16, 0, 1, 1});
        tbl.push_back(vec_t'{0, 0, 2'b00, 2'b00, ALU_SLL, 1, 32'h24, ALU_ADD, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0});

        rst = 1'b1; flush = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        req_op1 = '0; req_op2 = '0; req_alu_op[0] = ALU_ADD; req_alu_op[1] = ALU_ADD;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset rsp_valid", {30'b0, rsp_valid}, 0);
        chk("reset req_ready", {30'b0, req_ready}, 0);
        chk("reset rsp_out", rsp_out, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge clk);
            chk($sformatf("row%0d req_ready", i), {30'b0, req_ready}, {30'b0, tbl[i].e_rdy});
            chk($sformatf("row%0d rsp_valid", i), {30'b0, rsp_valid}, {30'b0, tbl[i].e_vld});
            if (tbl[i].e_vld != 2'b00) begin
                chk($sformatf("row%0d rsp_out", i), rsp_out, tbl[i].e_out);
                chk($sformatf("row%0d rsp_zero", i), {31'b0, rsp_zero}, {31'b0, tbl[i].e_z});
                chk($sformatf("row%0d rsp_lt", i), {31'b0, rsp_lt}, {31'b0, tbl[i].e_lt});
                chk($sformatf("row%0d rsp_ltu", i), {31'b0, rsp_ltu}, {31'b0, tbl[i].e_ltu});
            end
            @(posedge clk);
            #1;
        end

        // Continuous contention: grants alternate, one result per cycle, never two owners.
        last_g = 1'b0;
        prev_g = 2'b00;
        prev_out = '0;
        for (int k = 0; k < 12; k++) begin
            rst = 1'b0; flush = 1'b0; req_valid = 2'b11; rsp_ready = 2'b11;
            req_alu_op[0] = ALU_ADD; req_op1[0] = k;       req_op2[0] = 32'd1000;
            req_alu_op[1] = ALU_SUB; req_op1[1] = 100 + k; req_op2[1] = 32'd1;
            @(negedge clk);
            g = ~last_g;
            chk($sformatf("stream%0d req_ready", k), {30'b0, req_ready}, {30'b0, g, ~g});
            chk($sformatf("stream%0d rsp_valid", k), {30'b0, rsp_valid}, {30'b0, prev_g});
            chk($sformatf("stream%0d both_valid", k), {31'b0, (rsp_valid == 2'b11)}, 0);
            if (prev_g != 2'b00) chk($sformatf("stream%0d rsp_out", k), rsp_out, prev_out);
            prev_out = g ? (32'(100 + k) - 32'd1) : (32'(k) + 32'd1000);
            last_g = g;
            prev_g = {g, ~g};
            @(posedge clk);
            #1;
        end

        // Latency: accept from EMPTY, result must be visible the very next cycle.
        req_valid = 2'b00; rsp_ready = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b10; rsp_ready = 2'b00;
        req_alu_op[1] = ALU_OR; req_op1[1] = 32'h00F0; req_op2[1] = 32'h0F00;
        @(negedge clk);
        chk("lat req_ready", {30'b0, req_ready}, 32'h2);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            if (rsp_valid[1]) break;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("lat extra_cycles", lat, 0);
        chk("lat rsp_out", rsp_out, 32'h0FF0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
